// File: rtl/mod_acc_1481.sv
// mod_acc_1481: streaming frame sum modulo 1481 with beat count and range flag.
// Ports: clk/rst; din_r/din_valid/din_last/din_ready in; dout_* / err_range out.
module mod_acc_1481 #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [10:0]      din_r,
  input  logic             din_valid,
  input  logic             din_last,
  output logic             din_ready,
  output logic [10:0]      dout_sum,
  output logic [CNT_W-1:0] dout_count,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             err_range
);

  localparam logic [11:0] MOD = 12'd1481;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           r_state;
  logic [10:0]      r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic             w_take;
  logic             w_rng;
  logic [11:0]      w_din;
  logic [11:0]      w_v;
  logic [11:0]      w_s;
  logic [11:0]      w_s_red;
  logic [10:0]      w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;

  assign din_ready = (r_state == ACC) && !rst;
  assign w_take    = din_valid && din_ready;

  // One conditional subtraction per stage: inputs top out at 2047
  // and the accumulator stays below 1481, so both stages fit 12 bits.
  assign w_din      = {1'b0, din_r};
  assign w_rng      = w_din >= MOD;
  assign w_v        = w_rng ? w_din - MOD : w_din;
  assign w_s        = {1'b0, r_acc} + w_v;
  assign w_s_red    = (w_s >= MOD) ? w_s - MOD : w_s;
  assign w_acc_next = w_s_red[10:0];
  assign w_cnt_next = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ACC;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      dout_sum   <= '0;
      dout_count <= '0;
      err_range  <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ACC: begin
          if (w_take) begin
            if (din_last) begin
              dout_sum   <= w_acc_next;
              dout_count <= w_cnt_next;
              err_range  <= r_err | w_rng;
              dout_valid <= 1'b1;
              r_state    <= HOLD;
              r_acc      <= '0;
              r_cnt      <= '0;
              r_err      <= 1'b0;
            end else begin
              r_acc <= w_acc_next;
              r_cnt <= w_cnt_next;
              r_err <= r_err | w_rng;
            end
          end
        end
        HOLD: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            r_state    <= ACC;
          end
        end
        default: r_state <= ACC;
      endcase
    end
  end

endmodule

// File: doc/mod_acc_1481.md
MOD_ACC_1481 -- requirements
Module: mod_acc_1481

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; it SHALL have no other clock or reset.
REQ-002 Parameter SHALL be: CNT_W, 16, width of the beat counter output.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 din_r  input  11  residue input; 0..1480 is in range, as produced by the barret_for_1481 reducer output.
REQ-006 din_valid  input  1  din_r and din_last are valid.
REQ-007 din_last  input  1  current beat is the final beat of a frame.
REQ-008 din_ready  output  1  block can accept a beat.
REQ-009 dout_sum  output  11  frame sum mod 1481.
REQ-010 dout_count  output  CNT_W  number of beats in the frame.
REQ-011 dout_valid  output  1  dout_sum, dout_count and err_range are valid.
REQ-012 dout_ready  input  1  downstream consumes the result.
REQ-013 err_range  output  1  at least one beat in the frame had din_r >= 1481.

Function
REQ-014 The block SHALL have exactly two states, ACC and HOLD.
REQ-015 din_ready SHALL be 1 in ACC when rst=0, and 0 otherwise.
REQ-016 A beat SHALL be accepted only on a rising edge where din_valid=1 and din_ready=1.
- Input values are ignored on all other edges.
- din_valid gaps SHALL NOT affect the accumulation.
REQ-017 Each accepted beat SHALL be normalised first.
- v = din_r - 1481 if din_r >= 1481, else din_r.
- One subtraction suffices: max 2047 maps to 566.
REQ-018 The accumulator update SHALL be s = acc + v, computed at 12 bits.
- acc_next = s - 1481 if s >= 1481, else s.
- acc always stays in 0..1480.
REQ-019 The frame counter SHALL increment by 1 per accepted beat and wrap modulo 2^CNT_W.
REQ-020 The frame error flag SHALL be set on any accepted beat with din_r >= 1481.
REQ-021 On an accepted beat with din_last=1, at that same edge, the block SHALL:
- load dout_sum with acc_next;
- load dout_count with counter+1 (wrapped);
- load err_range with the error flag OR the current beat's range error;
- set dout_valid=1 and enter HOLD;
- clear acc, the counter and the error flag to 0.
REQ-022 Latency: dout_valid SHALL be high in the cycle immediately after the last beat is accepted.
REQ-023 A single-beat frame (first beat has din_last=1) SHALL produce dout_sum=v and dout_count=1.
REQ-024 In HOLD, dout_sum, dout_count, err_range and dout_valid SHALL stay stable until an edge with dout_ready=1.
REQ-025 At that edge the block SHALL clear dout_valid to 0 and return to ACC.
- din_ready rises in the following cycle; there is no same-cycle bypass.
REQ-026 In ACC, dout_valid SHALL be 0, and dout_sum/dout_count SHALL hold their last values.
REQ-027 dout_ready SHALL be ignored in ACC.

Reset
REQ-028 On a rising edge with rst=1, the block SHALL:
- enter ACC;
- clear acc, the counter, the error flag, dout_sum, dout_count, err_range and dout_valid to 0.
REQ-029 While rst=1, din_ready SHALL be 0 and no beat SHALL be accepted.
REQ-030 A reset mid-frame or in HOLD SHALL discard the partial frame or pending result with no output.
REQ-031 The first beat after reset release SHALL start a new frame.

Verification
REQ-032 Reset: hold rst=1 for 2 cycles -> din_ready=0, dout_valid=0, dout_sum=0, dout_count=0, err_range=0; after release din_ready=1.
REQ-033 Frame {1000, 500, 1480(last)} with a one-cycle din_valid gap between beats -> dout_sum=18, dout_count=3, err_range=0, dout_valid one cycle after the last beat.
REQ-034 Single beat 1480 with last=1 -> dout_sum=1480, dout_count=1.
REQ-035 Backpressure: dout_ready=0 for 5 cycles after a result -> outputs stable and din_ready=0 throughout; after dout_ready=1 the next frame {3, 4(last)} -> dout_sum=7, dout_count=2.
REQ-036 Out-of-range: frame {2047, 0(last)} -> dout_sum=566, err_range=1; next frame {1(last)} -> err_range=0.
REQ-037 Reset mid-frame after {700, 700} accepted, then frame {5(last)} -> dout_sum=5, dout_count=1.
